// File: rtl/ctrl_ret_stack_param_if.sv
// Purpose : control/status bundle between a return-stack user and ctrl_ret_stack_param.
// Latency : n/a (wires only); status signals reflect the stack state registered at the last edge.
// Backpr. : none; push/pop are accepted every cycle, errors are reported via sticky flags.
// Ports   : push/pop/push_addr/flush/err_clr from master; top_addr/count/empty/full/overflow/underflow
//           from slave. With CRS_CHECKPOINT_EN defined, ckpt_save/ckpt_restore are added (master->slave).
interface ctrl_ret_stack_param_if #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              flush;
    logic              err_clr;
    logic [ADDR_W-1:0] top_addr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

`ifdef CRS_CHECKPOINT_EN
    logic              ckpt_save;
    logic              ckpt_restore;

    modport master (
        output push, pop, push_addr, flush, err_clr, ckpt_save, ckpt_restore,
        input  top_addr, count, empty, full, overflow, underflow
    );
    modport slave (
        input  push, pop, push_addr, flush, err_clr, ckpt_save, ckpt_restore,
        output top_addr, count, empty, full, overflow, underflow
    );
`else
    modport master (
        output push, pop, push_addr, flush, err_clr,
        input  top_addr, count, empty, full, overflow, underflow
    );
    modport slave (
        input  push, pop, push_addr, flush, err_clr,
        output top_addr, count, empty, full, overflow, underflow
    );
`endif
endinterface

// File: rtl/ctrl_ret_stack_param.sv
// Purpose : parametrised call/return address stack (push on call, pop on return, push+pop = tail call).
// Latency : one cycle; a push/pop at edge N is visible on top_addr/count right after edge N.
// Backpr. : none; push when full saturates (OVF_MODE=0) or overwrites oldest (OVF_MODE=1), pop when
//           empty is ignored; both set sticky flags cleared by err_clr.
// Ports   : clk, reset (synchronous, active-high), bus (ctrl_ret_stack_param_if.slave).
// Option  : define CRS_CHECKPOINT_EN to add ckpt_save/ckpt_restore of {ptr, cnt} for branch recovery.
module ctrl_ret_stack_param #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0
) (
    input logic                   clk,
    input logic                   reset,
    ctrl_ret_stack_param_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr, ptr_nxt, top_idx, wr_idx;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              wr_en, ovf_ev, unf_ev;
    logic              ovf, unf;
    logic              is_empty, is_full;

`ifdef CRS_CHECKPOINT_EN
    logic [PTR_W-1:0]  shd_ptr;
    logic [CNT_W-1:0]  shd_cnt;
`endif

    // ptr is the next write slot; DEPTH is a power of 2 so the subtraction wraps for free.
    assign top_idx  = ptr - 1'b1;
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    assign bus.top_addr  = is_empty ? '0 : mem[top_idx];
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;

    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = ptr;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (bus.flush) begin
            ptr_nxt = '0;
            cnt_nxt = '0;
`ifdef CRS_CHECKPOINT_EN
        end else if (bus.ckpt_restore) begin
            ptr_nxt = shd_ptr;
            cnt_nxt = shd_cnt;
`endif
        end else if (bus.push && bus.pop) begin
            if (!is_empty) begin
                // Tail call: replace the top entry in place.
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                // Nothing to pop: flag it, then behave as a push into a fresh stack.
                unf_ev  = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = '0;
                ptr_nxt = PTR_W'(1);
                cnt_nxt = CNT_W'(1);
            end
        end else if (bus.push) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                ptr_nxt = ptr + 1'b1;
                cnt_nxt = cnt + 1'b1;
            end else begin
                ovf_ev = 1'b1;
                if (OVF_MODE == 1) begin
                    // Slot at ptr holds the oldest entry when full; overwrite it and keep cnt.
                    wr_en   = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                end
            end
        end else if (bus.pop) begin
            if (!is_empty) begin
                ptr_nxt = ptr - 1'b1;
                cnt_nxt = cnt - 1'b1;
            end else begin
                unf_ev = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            cnt <= cnt_nxt;
            // A new error event beats a simultaneous clear.
            if (ovf_ev)           ovf <= 1'b1;
            else if (bus.err_clr) ovf <= 1'b0;
            if (unf_ev)           unf <= 1'b1;
            else if (bus.err_clr) unf <= 1'b0;
        end
    end

    // Storage is deliberately not reset; cnt gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= bus.push_addr;
        end
    end

`ifdef CRS_CHECKPOINT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            shd_ptr <= '0;
            shd_cnt <= '0;
        end else if (bus.ckpt_save && !bus.ckpt_restore) begin
            shd_ptr <= ptr;
            shd_cnt <= cnt;
        end
    end
`endif
endmodule

// File: doc/ctrl_ret_stack_param.md
Name: ctrl_ret_stack_param

Overview:
Parametrised call/return address stack for the control path. It is the next generation of the 8-entry return stack.
- Push on JMP-class instructions; pop on JR RA.
- Configurable depth, address width and overflow policy.
- Same-cycle top-of-stack visibility, tail-call replace (push+pop), flush, occupancy count and sticky error flags.

Parameters:
ADDR_W, 10, width of stored return addresses
DEPTH, 8, number of entries; power of 2, >= 2
OVF_MODE, 0, 0 = saturate (drop push when full); 1 = circular (overwrite oldest entry when full)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
push  input  1  push push_addr
pop  input  1  pop top entry
push_addr  input  ADDR_W  address to push
flush  input  1  empty the stack (pipeline redirect/context switch)
err_clr  input  1  clear sticky overflow/underflow
top_addr  output  ADDR_W  current top entry; 0 when empty
count  output  $clog2(DEPTH)+1  number of valid entries
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- State:
  - storage array [DEPTH] x ADDR_W;
  - ptr, $clog2(DEPTH) bits, wraps mod DEPTH; it is the next write slot;
  - cnt, 0..DEPTH.
- Top index = (ptr-1) mod DEPTH.
- Outputs:
  - top_addr, empty, full and count are combinational from registered state.
  - top_addr = storage[top index] if cnt>0, else 0.
  - A push is visible on top_addr the cycle after the push edge; there is no extra lag.
- Reset: ptr=0, cnt=0, overflow=0, underflow=0. Hence top_addr=0, count=0, empty=1, full=0. Storage contents are not reset.
- Priority per edge: reset > flush > push/pop.
- flush: ptr=0, cnt=0; the sticky flags are unchanged; push/pop in the same cycle are ignored.
- push only:
  - cnt<DEPTH: write storage[ptr], ptr++, cnt++.
  - cnt==DEPTH with OVF_MODE=0: no write, state unchanged, overflow<=1.
  - cnt==DEPTH with OVF_MODE=1: write storage[ptr] (overwrites oldest), ptr++, cnt stays DEPTH, overflow<=1.
- pop only:
  - cnt>0: ptr--, cnt--.
  - cnt==0: no change, underflow<=1.
- push and pop together (tail-call replace):
  - cnt>0: write storage[top index]; ptr and cnt are unchanged.
  - cnt==0: underflow<=1, then a normal push: write storage[0], ptr=1, cnt=1.
- err_clr clears overflow/underflow. A new error event in the same cycle wins: the flag stays 1.
- Pointer wrap: ptr rolls DEPTH-1 -> 0 on push and 0 -> DEPTH-1 on pop. It is valid only in circular mode beyond DEPTH pushes.
- No combinational path from push/pop/push_addr to any output.

Optional Feature:
CRS_CHECKPOINT_EN
- Defined: adds inputs ckpt_save and ckpt_restore (1 bit each) for speculative branch recovery.
  - ckpt_save captures {ptr, cnt} into shadow registers.
  - ckpt_restore reloads {ptr, cnt} from the shadow. It has priority over push/pop but is below reset and flush.
  - Save+restore in the same cycle: restore wins; the shadow is not updated.
  - Shadow reset value is {0, 0}.
  - Entry contents overwritten after a save are not recovered; this is accepted inaccuracy.
- Undefined: ports and shadow registers are absent; behaviour is otherwise identical.

Test Plan:
Defaults DEPTH=8, ADDR_W=10, unless noted.
1. Reset, then push 0x011, 0x022, 0x033 -> count=3, top_addr=0x033 one cycle after the last push. Pop -> top_addr=0x022, count=2.
2. OVF_MODE=0: push 0x100..0x108 (9 pushes) -> full=1, count=8, overflow=1, top_addr=0x107. Eight pops -> sequence 0x107..0x100, then empty=1, top_addr=0.
3. OVF_MODE=1: push 0x200..0x209 (10 pushes) -> count=8, overflow=1. Pops return 0x209..0x202 in order.
4. Empty stack pop -> underflow=1, count=0. err_clr with a simultaneous pop on empty -> underflow stays 1. err_clr alone -> underflow=0.
5. Push 0x055, 0x066; then push+pop with 0x077 -> count=2, top_addr=0x077. Pop -> top_addr=0x055. On empty, push+pop with 0x3FF -> count=1, top_addr=0x3FF, underflow=1.
6. Push 0x001, 0x002; flush with a simultaneous push -> count=0, empty=1, flags unchanged.
   - With CRS_CHECKPOINT_EN: save at count=2, push 0x003, pop twice, restore -> count=2, top_addr=0x002.
